// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ requesters.
// One grant per complete transaction, with start/transfer watchdogs that abort stuck transactions.
module i2c_master_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int START_TIMEOUT = 64,
  parameter int XFER_TIMEOUT  = 2_000_000,
  parameter int PTR_W         = $clog2(NUM_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ*10-1:0] i_req_addr,
  input  logic [NUM_REQ*8-1:0]  i_req_byte_cnt,
  input  logic [NUM_REQ-1:0]    i_req_rd,
  input  logic [NUM_REQ*8-1:0]  i_req_tx_data,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic [NUM_REQ-1:0]    o_tx_data_needed,
  output logic [NUM_REQ-1:0]    o_rx_data_valid,
  output logic [7:0]            o_rx_data,
  output logic [NUM_REQ-1:0]    o_done,
  output logic [NUM_REQ-1:0]    o_nack,
  output logic [NUM_REQ-1:0]    o_timeout,
  output logic [9:0]            m_slave_addr,
  output logic [7:0]            m_byte_cnt,
  output logic [3:0]            m_control_reg,
  output logic [3:0]            m_mode_reg,
  output logic [7:0]            m_tx_data,
  input  logic                  m_tx_data_needed,
  input  logic                  m_rx_data_valid,
  input  logic [7:0]            m_rx_data,
  input  logic [4:0]            m_status_reg
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    XFER,
    FINISH
  } state_t;

  localparam logic [31:0] START_LIM = 32'(START_TIMEOUT - 1);
  localparam logic [31:0] XFER_LIM  = 32'(XFER_TIMEOUT - 1);
  localparam logic [3:0]  CTRL_START = 4'b1000;
  localparam logic [3:0]  CTRL_ABORT = 4'b0001;

  state_t               state_q;
  logic [PTR_W-1:0]     owner_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [9:0]           addr_q;
  logic [7:0]           cnt_q;
  logic                 rd_q;
  logic [3:0]           ctrl_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   nack_q;
  logic [NUM_REQ-1:0]   tmo_q;
  logic [31:0]          wdog_q;
  logic                 busy_q;

  logic [PTR_W-1:0]     sel_d;
  logic [NUM_REQ-1:0]   sel_oh_d;
  logic                 sel_vld_d;
  logic [31:0]          wdog_d;
  logic                 busy_fall;
  logic                 in_xfer;
  logic                 unused_status;

  assign unused_status = ^m_status_reg[3:1];

  // Round-robin search from ptr+1 upward with wrap; the lowest offset hit wins.
  always_comb begin
    int j;
    sel_d     = '0;
    sel_oh_d  = '0;
    sel_vld_d = 1'b0;
    j         = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (i_req[j]) begin
        sel_d     = PTR_W'(j);
        sel_oh_d  = '0;
        sel_oh_d[j] = 1'b1;
        sel_vld_d = 1'b1;
      end
    end
  end

  assign wdog_d    = (&wdog_q) ? wdog_q : wdog_q + 32'd1;
  assign busy_fall = busy_q && !m_status_reg[4];
  assign in_xfer   = (state_q == XFER);

  // Data handshakes are steered to the owner only, and only while the transfer is live.
  assign o_tx_data_needed = (in_xfer && m_tx_data_needed) ? grant_q : '0;
  assign o_rx_data_valid  = (in_xfer && m_rx_data_valid)  ? grant_q : '0;
  assign o_rx_data        = m_rx_data;
  assign m_tx_data        = in_xfer ? i_req_tx_data[int'(owner_q)*8 +: 8] : 8'h00;

  assign o_grant       = grant_q;
  assign o_done        = done_q;
  assign o_nack        = nack_q;
  assign o_timeout     = tmo_q;
  assign m_slave_addr  = addr_q;
  assign m_byte_cnt    = cnt_q;
  assign m_control_reg = ctrl_q;
  assign m_mode_reg    = {1'b0, rd_q, 2'b00};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      grant_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      ctrl_q  <= '0;
      done_q  <= '0;
      nack_q  <= '0;
      tmo_q   <= '0;
      wdog_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= m_status_reg[4];
      ctrl_q <= '0;
      done_q <= '0;
      nack_q <= '0;
      tmo_q  <= '0;
      case (state_q)
        IDLE: begin
          if (sel_vld_d) begin
            owner_q <= sel_d;
            grant_q <= sel_oh_d;
            addr_q  <= i_req_addr[int'(sel_d)*10 +: 10];
            cnt_q   <= i_req_byte_cnt[int'(sel_d)*8 +: 8];
            rd_q    <= i_req_rd[sel_d];
            ctrl_q  <= CTRL_START;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          wdog_q  <= '0;
          state_q <= WAIT_BUSY;
        end
        // Watchdog counts WAIT_BUSY cycles; abort fires when it reaches START_TIMEOUT.
        WAIT_BUSY: begin
          if (m_status_reg[4]) begin
            wdog_q  <= '0;
            state_q <= XFER;
          end else if (wdog_q >= START_LIM) begin
            ctrl_q  <= CTRL_ABORT;
            tmo_q   <= grant_q;
            grant_q <= '0;
            state_q <= FINISH;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        XFER: begin
          if (busy_fall) begin
            if (m_status_reg[0]) nack_q <= grant_q;
            else                 done_q <= grant_q;
            grant_q <= '0;
            state_q <= FINISH;
          end else if (wdog_q >= XFER_LIM) begin
            ctrl_q  <= CTRL_ABORT;
            tmo_q   <= grant_q;
            grant_q <= '0;
            state_q <= FINISH;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        FINISH: begin
          ptr_q   <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: cycle table for single-requester flows,
// plus hand sequences for round-robin order, transfer watchdog and mid-transfer reset.
module tb_i2c_master_arbiter;

  localparam int N  = 3;
  localparam int ST = 4;
  localparam int XT = 20;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic [N-1:0]  i_req;
  logic [N*10-1:0] i_req_addr;
  logic [N*8-1:0]  i_req_byte_cnt;
  logic [N-1:0]  i_req_rd;
  logic [N*8-1:0]  i_req_tx_data;
  logic [N-1:0]  o_grant, o_tx_data_needed, o_rx_data_valid, o_done, o_nack, o_timeout;
  logic [7:0]    o_rx_data;
  logic [9:0]    m_slave_addr;
  logic [7:0]    m_byte_cnt, m_tx_data, m_rx_data;
  logic [3:0]    m_control_reg, m_mode_reg;
  logic          m_tx_data_needed, m_rx_data_valid;
  logic [4:0]    m_status_reg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i2c_master_arbiter #(
    .NUM_REQ(N), .START_TIMEOUT(ST), .XFER_TIMEOUT(XT)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_req_addr(i_req_addr),
    .i_req_byte_cnt(i_req_byte_cnt), .i_req_rd(i_req_rd), .i_req_tx_data(i_req_tx_data),
    .o_grant(o_grant), .o_tx_data_needed(o_tx_data_needed), .o_rx_data_valid(o_rx_data_valid),
    .o_rx_data(o_rx_data), .o_done(o_done), .o_nack(o_nack), .o_timeout(o_timeout),
    .m_slave_addr(m_slave_addr), .m_byte_cnt(m_byte_cnt), .m_control_reg(m_control_reg),
    .m_mode_reg(m_mode_reg), .m_tx_data(m_tx_data), .m_tx_data_needed(m_tx_data_needed),
    .m_rx_data_valid(m_rx_data_valid), .m_rx_data(m_rx_data), .m_status_reg(m_status_reg)
  );

  typedef struct {
    logic [2:0] req;
    logic [3:0] bntr;   // {busy, status nack, tx_needed, rx_valid}
    logic [7:0] rxd;
    logic [7:0] txd;
    logic [2:0] g;
    logic [3:0] c;
    logic [3:0] m;
    logic [2:0] otx;
    logic [2:0] orx;
    logic [2:0] d;
    logic [2:0] nk;
    logic [2:0] to;
  } vec_t;

  vec_t tbl[31];

  function automatic vec_t V(logic [2:0] req, logic [3:0] bntr, logic [7:0] rxd, logic [7:0] txd,
                             logic [2:0] g, logic [3:0] c, logic [3:0] m, logic [2:0] otx,
                             logic [2:0] orx, logic [2:0] d, logic [2:0] nk, logic [2:0] to);
    vec_t v;
    v.req = req; v.bntr = bntr; v.rxd = rxd; v.txd = txd; v.g = g; v.c = c; v.m = m;
    v.otx = otx; v.orx = orx; v.d = d; v.nk = nk; v.to = to;
    return v;
  endfunction

  function automatic logic [9:0] exp_addr(int k);
    return (k == 2) ? 10'h3C5 : 10'h055;
  endfunction

  function automatic logic [7:0] exp_cnt(int k);
    return (k == 0) ? 8'd2 : ((k == 1) ? 8'd1 : 8'd3);
  endfunction

  function automatic int oh2idx(logic [2:0] g);
    int r = 0;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " grant"}, 32'(o_grant), 0);
    chk({tag, " ctrl"}, 32'(m_control_reg), 0);
    chk({tag, " mode"}, 32'(m_mode_reg), 0);
    chk({tag, " addr"}, 32'(m_slave_addr), 0);
    chk({tag, " cnt"}, 32'(m_byte_cnt), 0);
    chk({tag, " txn"}, 32'(o_tx_data_needed), 0);
    chk({tag, " rxv"}, 32'(o_rx_data_valid), 0);
    chk({tag, " done"}, 32'(o_done), 0);
    chk({tag, " nack"}, 32'(o_nack), 0);
    chk({tag, " tmo"}, 32'(o_timeout), 0);
    chk({tag, " mtx"}, 32'(m_tx_data), 0);
  endtask

  task automatic wait_grant(input string tag);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_grant != '0) break;
    end
    checks++;
    if (o_grant == '0) begin
      errors++;
      $display("FAIL %s grant wait: got 0 expected nonzero within 8 cycles", tag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] g;
    int ow;

    tbl[0]  = V(3'b001, 4'b0000, 8'h00, 8'h02, 3'b001, 4'h8, 4'h0, 0, 0, 0, 0, 0);
    tbl[1]  = V(3'b001, 4'b0000, 8'h00, 8'h02, 3'b001, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[2]  = V(3'b001, 4'b1000, 8'h00, 8'h02, 3'b001, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[3]  = V(3'b001, 4'b1010, 8'h00, 8'h02, 3'b001, 4'h0, 4'h0, 3'b001, 0, 0, 0, 0);
    tbl[4]  = V(3'b001, 4'b1000, 8'h00, 8'h57, 3'b001, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[5]  = V(3'b001, 4'b1010, 8'h00, 8'h57, 3'b001, 4'h0, 4'h0, 3'b001, 0, 0, 0, 0);
    tbl[6]  = V(3'b001, 4'b1000, 8'h00, 8'h57, 3'b001, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[7]  = V(3'b001, 4'b0000, 8'h00, 8'h57, 3'b000, 4'h0, 4'h0, 0, 0, 3'b001, 0, 0);
    tbl[8]  = V(3'b000, 4'b0000, 8'h00, 8'h00, 3'b000, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[9]  = V(3'b000, 4'b0000, 8'h00, 8'h00, 3'b000, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[10] = V(3'b010, 4'b0000, 8'h00, 8'h00, 3'b010, 4'h8, 4'h4, 0, 0, 0, 0, 0);
    tbl[11] = V(3'b010, 4'b0000, 8'h00, 8'h00, 3'b010, 4'h0, 4'h4, 0, 0, 0, 0, 0);
    tbl[12] = V(3'b010, 4'b1000, 8'h00, 8'h00, 3'b010, 4'h0, 4'h4, 0, 0, 0, 0, 0);
    tbl[13] = V(3'b010, 4'b1001, 8'hA5, 8'h00, 3'b010, 4'h0, 4'h4, 0, 3'b010, 0, 0, 0);
    tbl[14] = V(3'b010, 4'b1000, 8'h00, 8'h00, 3'b010, 4'h0, 4'h4, 0, 0, 0, 0, 0);
    tbl[15] = V(3'b010, 4'b0000, 8'h00, 8'h00, 3'b000, 4'h0, 4'h4, 0, 0, 3'b010, 0, 0);
    tbl[16] = V(3'b000, 4'b0000, 8'h00, 8'h00, 3'b000, 4'h0, 4'h4, 0, 0, 0, 0, 0);
    tbl[17] = V(3'b101, 4'b0000, 8'h00, 8'h00, 3'b100, 4'h8, 4'h0, 0, 0, 0, 0, 0);
    tbl[18] = V(3'b101, 4'b0000, 8'h00, 8'h00, 3'b100, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[19] = V(3'b101, 4'b1000, 8'h00, 8'h00, 3'b100, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[20] = V(3'b101, 4'b1000, 8'h00, 8'h00, 3'b100, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[21] = V(3'b101, 4'b0100, 8'h00, 8'h00, 3'b000, 4'h0, 4'h0, 0, 0, 0, 3'b100, 0);
    tbl[22] = V(3'b001, 4'b0000, 8'h00, 8'h00, 3'b000, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[23] = V(3'b001, 4'b0000, 8'h00, 8'h00, 3'b001, 4'h8, 4'h0, 0, 0, 0, 0, 0);
    tbl[24] = V(3'b001, 4'b0000, 8'h00, 8'h00, 3'b001, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[25] = V(3'b001, 4'b0000, 8'h00, 8'h00, 3'b001, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[26] = V(3'b001, 4'b0000, 8'h00, 8'h00, 3'b001, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[27] = V(3'b001, 4'b0000, 8'h00, 8'h00, 3'b001, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[28] = V(3'b001, 4'b0000, 8'h00, 8'h00, 3'b000, 4'h1, 4'h0, 0, 0, 0, 0, 3'b001);
    tbl[29] = V(3'b000, 4'b0000, 8'h00, 8'h00, 3'b000, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    tbl[30] = V(3'b000, 4'b0000, 8'h00, 8'h00, 3'b000, 4'h0, 4'h0, 0, 0, 0, 0, 0);

    i_rst_n          = 1'b0;
    i_req            = '0;
    i_req_addr       = {10'h3C5, 10'h055, 10'h055};
    i_req_byte_cnt   = {8'd3, 8'd1, 8'd2};
    i_req_rd         = 3'b010;
    i_req_tx_data    = {8'hC2, 8'hB1, 8'h00};
    m_tx_data_needed = 1'b0;
    m_rx_data_valid  = 1'b0;
    m_rx_data        = 8'h00;
    m_status_reg     = 5'h00;
    tick(); tick(); tick();
    check_zero("reset");
    i_rst_n = 1'b1;

    for (int r = 0; r < 31; r++) begin
      i_req            = tbl[r].req;
      m_status_reg     = {tbl[r].bntr[3], 3'b000, tbl[r].bntr[2]};
      m_tx_data_needed = tbl[r].bntr[1];
      m_rx_data_valid  = tbl[r].bntr[0];
      m_rx_data        = tbl[r].rxd;
      i_req_tx_data    = {8'hC2, 8'hB1, tbl[r].txd};
      tick();
      chk($sformatf("r%0d grant", r), 32'(o_grant), 32'(tbl[r].g));
      chk($sformatf("r%0d ctrl", r), 32'(m_control_reg), 32'(tbl[r].c));
      chk($sformatf("r%0d mode", r), 32'(m_mode_reg), 32'(tbl[r].m));
      chk($sformatf("r%0d txn", r), 32'(o_tx_data_needed), 32'(tbl[r].otx));
      chk($sformatf("r%0d rxv", r), 32'(o_rx_data_valid), 32'(tbl[r].orx));
      chk($sformatf("r%0d rxd", r), 32'(o_rx_data), 32'(tbl[r].rxd));
      chk($sformatf("r%0d done", r), 32'(o_done), 32'(tbl[r].d));
      chk($sformatf("r%0d nack", r), 32'(o_nack), 32'(tbl[r].nk));
      chk($sformatf("r%0d tmo", r), 32'(o_timeout), 32'(tbl[r].to));
      if (tbl[r].g != '0) begin
        ow = oh2idx(tbl[r].g);
        chk($sformatf("r%0d addr", r), 32'(m_slave_addr), 32'(exp_addr(ow)));
        chk($sformatf("r%0d cnt", r), 32'(m_byte_cnt), 32'(exp_cnt(ow)));
      end
      if (tbl[r].otx != '0)
        chk($sformatf("r%0d mtx", r), 32'(m_tx_data), 32'(tbl[r].txd));
    end

    // Round-robin order from reset with all three requesting together.
    i_rst_n = 1'b0;
    i_req   = '0;
    m_status_reg = '0;
    tick();
    i_rst_n = 1'b1;
    i_req   = 3'b111;
    for (int n = 0; n < N; n++) begin
      wait_grant($sformatf("rr%0d", n));
      chk($sformatf("rr%0d order", n), 32'(o_grant), 32'(3'b001 << n));
      chk($sformatf("rr%0d start", n), 32'(m_control_reg), 32'h8);
      g = o_grant;
      tick();
      m_status_reg = 5'h10;
      tick();
      tick();
      m_status_reg = 5'h00;
      tick();
      chk($sformatf("rr%0d done", n), 32'(o_done), 32'(g));
      chk($sformatf("rr%0d nack", n), 32'(o_nack), 0);
      chk($sformatf("rr%0d gap", n), 32'(o_grant), 0);
      i_req = i_req & ~g;
      tick();
      chk($sformatf("rr%0d idle", n), 32'(o_grant), 0);
      chk($sformatf("rr%0d single", n), 32'(o_done), 0);
    end

    // Transfer watchdog: busy never falls.
    i_req = 3'b001;
    wait_grant("xto");
    chk("xto grant", 32'(o_grant), 32'h1);
    tick();
    m_status_reg = 5'h10;
    tick();
    for (int k = 1; k < XT; k++) tick();
    chk("xto early", 32'(o_timeout), 0);
    chk("xto held", 32'(o_grant), 32'h1);
    tick();
    chk("xto tmo", 32'(o_timeout), 32'h1);
    chk("xto abort", 32'(m_control_reg), 32'h1);
    chk("xto grant off", 32'(o_grant), 0);
    chk("xto no done", 32'(o_done), 0);
    m_status_reg = 5'h00;
    i_req = '0;
    tick();
    tick();

    // Reset in the middle of a transfer.
    i_req = 3'b010;
    wait_grant("rst");
    chk("rst grant", 32'(o_grant), 32'h2);
    tick();
    m_status_reg = 5'h10;
    tick();
    m_tx_data_needed = 1'b1;
    #1;
    chk("rst txn route", 32'(o_tx_data_needed), 32'h2);
    chk("rst mtx", 32'(m_tx_data), 32'hB1);
    i_rst_n = 1'b0;
    tick();
    check_zero("midrst");
    m_status_reg     = 5'h00;
    m_tx_data_needed = 1'b0;
    i_req            = 3'b011;
    i_rst_n          = 1'b1;
    tick();
    chk("post-rst grant", 32'(o_grant), 32'h1);
    chk("post-rst start", 32'(m_control_reg), 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
Shares one i2c_master instance between N independent requesters (e.g. sensor poller, EEPROM loader, CPU bridge). Round-robin arbitration grants one requester per complete I2C transaction. The block drives the master's address, byte-count, mode and control inputs, and steers the tx/rx byte handshakes to and from the granted requester only. Adds a watchdog that aborts transactions that never start or never finish.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
START_TIMEOUT, 64, max cycles from start pulse to master busy rising
XFER_TIMEOUT, 2_000_000, max cycles with master busy for a single transaction
PTR_W, $clog2(NUM_REQ), round-robin pointer width (derived)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous, active-low reset
i_req  in  NUM_REQ  per-requester transaction request, level; hold until o_done/o_nack/o_timeout
i_req_addr  in  NUM_REQ*10  packed slave addresses, requester k at [10k+9:10k]
i_req_byte_cnt  in  NUM_REQ*8  packed byte counts
i_req_rd  in  NUM_REQ  1 = read, 0 = write
i_req_tx_data  in  NUM_REQ*8  packed tx bytes, sampled by master when tx byte requested
o_grant  out  NUM_REQ  one-hot current owner, all-zero when idle
o_tx_data_needed  out  NUM_REQ  master tx request routed to owner only
o_rx_data_valid  out  NUM_REQ  master rx valid routed to owner only
o_rx_data  out  8  master rx byte, shared
o_done  out  NUM_REQ  1-cycle pulse, transaction ended without NACK
o_nack  out  NUM_REQ  1-cycle pulse, transaction ended with NACK
o_timeout  out  NUM_REQ  1-cycle pulse, watchdog abort
m_slave_addr  out  10  to master i_slave_addr
m_byte_cnt  out  8  to master i_byte_cnt
m_control_reg  out  4  bit3 = start pulse, bit0 = abort pulse, others 0
m_mode_reg  out  4  bit2 = read, others 0
m_tx_data  out  8  to master i_tx_data
m_tx_data_needed  in  1  from master
m_rx_data_valid  in  1  from master
m_rx_data  in  8  from master
m_status_reg  in  5  bit4 = busy, bit0 = NACK seen (valid at busy fall)

Behaviour:
- Reset (i_rst_n=0 at posedge): all outputs 0, state IDLE, rr pointer = NUM_REQ-1, so requester 0 has first priority. Reset mid-transaction drops the grant immediately; the master is not explicitly aborted.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, XFER, FINISH.
- IDLE: if any i_req bit is set, choose the first set bit searching from ptr+1 upward with wrap. Register the owner, o_grant, m_slave_addr, m_byte_cnt and m_mode_reg[2]. Go to LAUNCH. The grant is visible 1 cycle after i_req.
- LAUNCH: m_control_reg = 4'b1000 for exactly 1 cycle, then WAIT_BUSY. Clear the watchdog.
- WAIT_BUSY: on m_status_reg[4]=1 go to XFER and clear the watchdog. If the watchdog reaches START_TIMEOUT first, pulse m_control_reg[0] for 1 cycle, pulse o_timeout[owner], and go to FINISH.
- XFER: o_tx_data_needed[owner] = m_tx_data_needed, o_rx_data_valid[owner] = m_rx_data_valid (combinational, other bits 0). m_tx_data = owner's i_req_tx_data slice (combinational mux). o_rx_data = m_rx_data always. On busy falling (1 to 0), sample m_status_reg[0] and pulse o_nack[owner] if set, else o_done[owner]. If the watchdog reaches XFER_TIMEOUT, pulse abort and o_timeout[owner].
- FINISH: ptr = owner, o_grant = 0; return to IDLE the next cycle. Minimum 1 idle cycle between transactions, so back-to-back requests from another requester are granted 2 cycles after o_done.
- Exactly one of o_done/o_nack/o_timeout pulses per grant.
- Deasserting i_req mid-transaction is ignored; the transaction completes.
- A requester re-asserting immediately after done yields to any other pending requester (fairness). A sole requester is re-granted.
- m_slave_addr, m_byte_cnt and m_mode_reg stay constant from grant through FINISH.
- Byte count 0 is forwarded unchanged; master behaviour is the master's concern.
- Watchdog is a 32-bit saturating counter.

Test Plan:
1. Reset, then req0 write addr 0x55, cnt 2, data 0x02/0x57 -> o_grant=001 one cycle later; m_control_reg=1000 for 1 cycle; two tx_data_needed pulses routed to bit0 only; o_done=001 one pulse after busy falls.
2. i_req=111 simultaneously, each holding until done -> grant order 0,1,2; each has one o_done; no overlap; o_grant=000 between.
3. req1 read addr 0x55, cnt 1, slave returns 0xA5 -> o_rx_data_valid=010 pulse with o_rx_data=0xA5; m_mode_reg=0100 throughout; o_done[1].
4. Slave NACKs address, status[0]=1 at busy fall -> o_nack[owner] pulse, no o_done; next pending requester granted 2 cycles later.
5. Master busy held low after start -> at START_TIMEOUT, m_control_reg=0001 for 1 cycle and o_timeout[owner] pulse; arbiter returns to IDLE.
6. i_rst_n=0 during XFER -> next cycle all outputs 0; after release, req0 pending is granted first.
